// File: rtl/sdram_rcache_pkg.sv
// Shared constants for the SDRAM read cache and the controller wrapper.
package sdram_rcache_pkg;
  localparam int ADDR_W_DEF = 27;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;
endpackage

// File: rtl/rcache_ram.sv
// Direct-mapped byte store: valid flops, tag and data arrays, one write port.
module rcache_ram
  import sdram_rcache_pkg::*;
#(
  parameter int INDEX_W = 8,
  parameter int TAG_W   = 19
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               inval,
  input  logic               we,
  input  logic [INDEX_W-1:0] rd_idx,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [7:0]         wr_data,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [7:0]         rd_data
);
  localparam int ENTRIES = 1 << INDEX_W;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_ram  [ENTRIES];
  logic [7:0]         data_ram [ENTRIES];

  // A write on the invalidate edge still leaves its own entry valid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
    end else begin
      if (inval) valid <= '0;
      if (we)    valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (we) begin
      tag_ram[wr_idx]  <= wr_tag;
      data_ram[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_ram[rd_idx];
  assign rd_data  = data_ram[rd_idx];
endmodule

// File: rtl/sdram_rcache.sv
// Direct-mapped write-through, write-allocate byte cache in front of the
// SDRAM controller request port; stalls the CPU through cpu_ce.
module sdram_rcache
  import sdram_rcache_pkg::*;
#(
  parameter  int ADDR_W  = ADDR_W_DEF,
  parameter  int INDEX_W = 8,
  localparam int TAG_W   = ADDR_W - INDEX_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_mreq,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [7:0]        cpu_in,
  output logic [7:0]        cpu_out,
  output logic              cpu_ce,
  input  logic              flush,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_mreq,
  output logic              mem_read,
  output logic              mem_write,
  output logic [7:0]        mem_in,
  input  logic [7:0]        mem_out,
  input  logic              mem_ce,
  output logic              stat_hit
);
  logic [1:0]         state;
  logic               req_q;
  logic               wr_done;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [7:0]         rd_data;
  logic               hit, idle_wr, idle_rd_miss, fill, we;

  assign idx = cpu_address[INDEX_W-1:0];
  assign tag = cpu_address[ADDR_W-1:INDEX_W];

  // A flush on the same edge makes a coincident read a miss.
  assign hit = rd_valid && (rd_tag == tag) && !flush;

  // wr_done marks the one cycle after a write finishes, so a CPU still
  // holding the strobe advances instead of issuing the write again.
  assign idle_wr      = (state == ST_IDLE) && cpu_mreq && cpu_write && !wr_done;
  assign idle_rd_miss = (state == ST_IDLE) && cpu_mreq && cpu_read && !hit && !idle_wr;
  assign cpu_ce       = (state == ST_IDLE) &&
                        !(cpu_mreq && ((cpu_write && !wr_done) || (cpu_read && !hit)));
  assign fill         = (state == ST_WAIT) && mem_ce && (req_q == REQ_READ);
  assign we           = idle_wr || fill;
  assign cpu_out      = rd_data;

  rcache_ram #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_ram (
    .clock   (clock),
    .reset_n (reset_n),
    .inval   (flush),
    .we      (we),
    .rd_idx  (idx),
    .wr_idx  (idle_wr ? idx : mem_address[INDEX_W-1:0]),
    .wr_tag  (idle_wr ? tag : mem_address[ADDR_W-1:INDEX_W]),
    .wr_data (idle_wr ? cpu_in : mem_out),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      req_q       <= REQ_READ;
      wr_done     <= 1'b0;
      mem_address <= '0;
      mem_in      <= '0;
      mem_mreq    <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      stat_hit    <= 1'b0;
    end else begin
      stat_hit <= (state == ST_IDLE) && cpu_mreq && cpu_read && !cpu_write && hit;
      wr_done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (idle_wr) begin
            mem_address <= cpu_address;
            mem_in      <= cpu_in;
            mem_write   <= 1'b1;
            mem_mreq    <= 1'b1;
            req_q       <= REQ_WRITE;
            state       <= ST_REQ;
          end else if (idle_rd_miss) begin
            mem_address <= cpu_address;
            mem_read    <= 1'b1;
            mem_mreq    <= 1'b1;
            req_q       <= REQ_READ;
            state       <= ST_REQ;
          end
        end
        // Drop mreq once accepted so the controller cannot repeat the transfer.
        ST_REQ: begin
          if (!mem_ce) begin
            mem_mreq <= 1'b0;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_ce) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            wr_done   <= (req_q == REQ_WRITE);
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_rcache.sv
// Randomized and directed bench for sdram_rcache against a behavioural cache model.
module tb_sdram_rcache;
  localparam int AW   = 27;
  localparam int IW   = 8;
  localparam int TW   = AW - IW;
  localparam int BUSY = 8;

  logic          clock, reset_n;
  logic [AW-1:0] cpu_address;
  logic          cpu_mreq, cpu_read, cpu_write, flush;
  logic [7:0]    cpu_in, cpu_out;
  logic          cpu_ce;
  logic [AW-1:0] mem_address;
  logic          mem_mreq, mem_read, mem_write;
  logic [7:0]    mem_in, mem_out;
  logic          mem_ce, stat_hit;

  int passed = 0;
  int total  = 0;

  sdram_rcache dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_address(cpu_address), .cpu_mreq(cpu_mreq), .cpu_read(cpu_read),
    .cpu_write(cpu_write), .cpu_in(cpu_in), .cpu_out(cpu_out), .cpu_ce(cpu_ce),
    .flush(flush),
    .mem_address(mem_address), .mem_mreq(mem_mreq), .mem_read(mem_read),
    .mem_write(mem_write), .mem_in(mem_in), .mem_out(mem_out), .mem_ce(mem_ce),
    .stat_hit(stat_hit)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // SDRAM contents: untouched locations read as a fixed address hash.
  logic [7:0] sdram [logic [AW-1:0]];

  function automatic logic [7:0] mem_val(input logic [AW-1:0] a);
    if (sdram.exists(a)) return sdram[a];
    return a[7:0] ^ a[15:8] ^ a[26:19] ^ 8'h5A;
  endfunction

  // Controller model: accepts on mreq, busy (mem_ce=0) for BUSY clocks.
  int            n_rd = 0, n_wr = 0;
  logic [AW-1:0] last_addr;
  logic [7:0]    last_din;
  initial begin
    bit            busy;
    int            cnt;
    bit            op_wr;
    logic [AW-1:0] a;
    logic [7:0]    d;
    busy = 0; cnt = 0; op_wr = 0; a = '0; d = '0;
    mem_ce = 1'b1; mem_out = 8'h00;
    forever begin
      @(negedge clock);
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          if (op_wr) sdram[a] = d;
          else       mem_out = mem_val(a);
          mem_ce = 1'b1;
          busy   = 0;
        end
      end else if (mem_mreq) begin
        busy = 1; cnt = BUSY; op_wr = mem_write; a = mem_address; d = mem_in;
        last_addr = a; last_din = d;
        if (op_wr) n_wr++; else n_rd++;
        mem_ce = 1'b0;
      end
    end
  end

  // Reference cache state.
  bit            rv [256];
  logic [TW-1:0] rt [256];

  function automatic bit ref_hit(input logic [AW-1:0] a);
    return rv[a[IW-1:0]] && (rt[a[IW-1:0]] == a[AW-1:IW]);
  endfunction

  task automatic ref_clear();
    for (int i = 0; i < 256; i++) rv[i] = 0;
  endtask

  task automatic access(input logic [AW-1:0] a, input bit rd, input bit wr,
                        input logic [7:0] d, input string nm);
    bit         exp_hit;
    int         n0r, n0w, cyc, exp_lat, exp_dr, exp_dw;
    logic [7:0] got, exp_data;
    logic       st_ce, st_after;
    exp_hit  = !wr && rd && ref_hit(a);
    exp_lat  = exp_hit ? 0 : BUSY + 2;
    exp_dr   = (rd && !wr && !exp_hit) ? 1 : 0;
    exp_dw   = wr ? 1 : 0;
    exp_data = wr ? d : mem_val(a);
    n0r = n_rd; n0w = n_wr;
    @(negedge clock);
    cpu_address = a; cpu_read = rd; cpu_write = wr; cpu_in = d; cpu_mreq = 1'b1;
    #1;
    cyc = 0;
    while (!cpu_ce && cyc < 200) begin
      @(posedge clock); #1; cyc++;
    end
    got = cpu_out; st_ce = stat_hit;
    @(posedge clock); #1;
    st_after = stat_hit;
    @(negedge clock);
    cpu_mreq = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;

    total++;
    if (cyc !== exp_lat) $display("FAIL %s latency got %0d want %0d", nm, cyc, exp_lat);
    else passed++;
    total++;
    if ((n_rd - n0r) !== exp_dr || (n_wr - n0w) !== exp_dw)
      $display("FAIL %s mem_req rd/wr got %0d/%0d want %0d/%0d", nm, n_rd - n0r, n_wr - n0w, exp_dr, exp_dw);
    else passed++;
    if (wr) begin
      total++;
      if (last_addr !== a || last_din !== d)
        $display("FAIL %s mem_write addr/data got %h/%h want %h/%h", nm, last_addr, last_din, a, d);
      else passed++;
    end
    if (rd) begin
      total++;
      if (got !== exp_data) $display("FAIL %s cpu_out got %h want %h", nm, got, exp_data);
      else passed++;
    end
    if (exp_hit || wr) begin
      total++;
      if (st_after !== exp_hit) $display("FAIL %s stat_hit got %b want %b", nm, st_after, exp_hit);
      else passed++;
    end else if (rd) begin
      total++;
      if (st_ce !== 1'b0) $display("FAIL %s stat_hit on miss got %b want 0", nm, st_ce);
      else passed++;
    end

    if (wr) begin
      sdram[a] = d;
      rv[a[IW-1:0]] = 1; rt[a[IW-1:0]] = a[AW-1:IW];
    end else if (rd && !exp_hit) begin
      rv[a[IW-1:0]] = 1; rt[a[IW-1:0]] = a[AW-1:IW];
    end
  endtask

  task automatic flush_pulse();
    @(negedge clock); flush = 1'b1;
    @(negedge clock); flush = 1'b0;
    ref_clear();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cpu_address = '0; cpu_mreq = 0; cpu_read = 0; cpu_write = 0; cpu_in = 0; flush = 0;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if (cpu_ce !== 1'b1 || mem_mreq !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 ||
        mem_address !== '0 || mem_in !== 8'h00 || stat_hit !== 1'b0)
      $display("FAIL reset outputs got ce=%b mreq=%b rd=%b wr=%b addr=%h in=%h hit=%b want 1/0/0/0/0/0/0",
               cpu_ce, mem_mreq, mem_read, mem_write, mem_address, mem_in, stat_hit);
    else passed++;
    @(negedge clock); reset_n = 1'b1;
    ref_clear();
  endtask

  task automatic test_read_miss_hit();
    sdram[27'h0000123] = 8'hA5;
    access(27'h0000123, 1, 0, 8'h00, "read_miss");
    access(27'h0000123, 1, 0, 8'h00, "read_hit");
  endtask

  task automatic test_write();
    access(27'h0000200, 0, 1, 8'h3C, "write");
    access(27'h0000200, 1, 0, 8'h00, "read_after_write");
  endtask

  task automatic test_alias();
    sdram[27'h0000105] = 8'h11;
    sdram[27'h0100105] = 8'h22;
    access(27'h0000105, 1, 0, 8'h00, "alias_a");
    access(27'h0100105, 1, 0, 8'h00, "alias_b");
    access(27'h0000105, 1, 0, 8'h00, "alias_a_again");
  endtask

  task automatic test_flush();
    access(27'h0000105, 1, 0, 8'h00, "flush_prefill");
    flush_pulse();
    access(27'h0000105, 1, 0, 8'h00, "after_flush");
    // Flush coincident with a read that would otherwise hit.
    begin
      int n0, cyc;
      n0 = n_rd;
      @(negedge clock);
      cpu_address = 27'h0000105; cpu_read = 1; cpu_write = 0; cpu_mreq = 1; flush = 1;
      #1;
      total++;
      if (cpu_ce !== 1'b0) $display("FAIL flush_coincident cpu_ce got %b want 0", cpu_ce);
      else passed++;
      @(negedge clock); flush = 0;
      ref_clear();
      cyc = 0;
      while (!cpu_ce && cyc < 200) begin @(posedge clock); #1; cyc++; end
      @(posedge clock); #1;
      @(negedge clock); cpu_mreq = 0; cpu_read = 0;
      total++;
      if ((n_rd - n0) !== 1) $display("FAIL flush_coincident reads got %0d want 1", n_rd - n0);
      else passed++;
      rv[8'h05] = 1; rt[8'h05] = '0;
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    @(negedge clock);
    cpu_address = 27'h0000333; cpu_read = 1; cpu_write = 0; cpu_mreq = 1;
    cyc = 0;
    while (!(mem_read === 1'b1 && mem_mreq === 1'b0) && cyc < 200) begin
      @(posedge clock); #1; cyc++;
    end
    total++;
    if (cyc >= 200) $display("FAIL reset_mid reach_wait got timeout want wait state");
    else passed++;
    @(negedge clock);
    reset_n = 0; cpu_mreq = 0; cpu_read = 0;
    #1;
    total++;
    if (mem_mreq !== 1'b0 || mem_read !== 1'b0 || cpu_ce !== 1'b1)
      $display("FAIL reset_mid outputs got mreq=%b rd=%b ce=%b want 0/0/1", mem_mreq, mem_read, cpu_ce);
    else passed++;
    cyc = 0;
    while (mem_ce !== 1'b1 && cyc < 200) begin @(posedge clock); #1; cyc++; end
    @(negedge clock); reset_n = 1;
    ref_clear();
    access(27'h0000333, 1, 0, 8'h00, "reset_mid_refetch");
  endtask

  task automatic test_rw_both();
    access(27'h0000010, 1, 1, 8'h7E, "rw_both");
    access(27'h0000010, 1, 0, 8'h00, "rw_both_readback");
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [IW-1:0] ix;
    logic [TW-1:0] tg;
    int op;
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 9) == 0) flush_pulse();
      case ($urandom_range(0, 3))
        0: ix = 8'h05;
        1: ix = 8'h10;
        2: ix = 8'hFF;
        default: ix = 8'h00;
      endcase
      case ($urandom_range(0, 2))
        0: tg = '0;
        1: tg = 19'h00001;
        default: tg = 19'h7FFFF;
      endcase
      a  = {tg, ix};
      op = $urandom_range(0, 7);
      if (op <= 4)      access(a, 1, 0, 8'h00, "rand_read");
      else if (op <= 6) access(a, 0, 1, 8'($urandom), "rand_write");
      else              access(a, 1, 1, 8'($urandom), "rand_rw");
    end
  endtask

  initial begin
    test_reset();
    test_read_miss_hit();
    test_write();
    test_alias();
    test_flush();
    test_reset_mid();
    test_rw_both();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
